seg7_scan_display: RTL and testbench



---
 rtl/seg7_scan_display.sv | 137 +++++++++++++
 tb/tb_seg7_scan_display.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - four-digit multiplexed seven-segment driver with frame-aligned value commit
module seg7_scan_display #(
    parameter int CLOCK_FREQ   = 100_000_000,
    parameter int REFRESH_HZ   = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic        value_valid,
    input  logic        freeze,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int DIGIT_TICKS = CLOCK_FREQ / (4 * REFRESH_HZ);
    localparam int CW          = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   pend_val;
    logic [3:0]    pend_dp;
    logic          pend_full;
    logic [15:0]   disp_val;
    logic [3:0]    disp_dp;
    logic          wrap_q;

    logic          slot_end;
    logic          wrap;
    logic          capture;
    logic [15:0]   disp_shift;
    logic          digit_blank;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;

    // Slot/frame boundary detection and capture qualification
    always_comb begin
        slot_end = (cnt == CW'(DIGIT_TICKS - 1));
        wrap     = slot_end && (idx == 2'd3);
        capture  = value_valid && !freeze;
    end

    // Current digit nibble, leading-zero test and anode selection
    always_comb begin
        disp_shift  = disp_val >> {idx, 2'b00};
        digit_blank = blank_lz && (idx != 2'd0) && (disp_shift == 16'h0000);
        an_next     = 4'hF;
        if (!(cnt < CW'(BLANK_CYCLES)) && !digit_blank) begin
            an_next = ~(4'b0001 << idx);
        end
    end

    // Hex nibble to active-low {g,f,e,d,c,b,a}
    always_comb begin
        seg_next = 7'h7F;
        case (disp_shift[3:0])
            4'h0: seg_next = 7'b1000000;
            4'h1: seg_next = 7'b1111001;
            4'h2: seg_next = 7'b0100100;
            4'h3: seg_next = 7'b0110000;
            4'h4: seg_next = 7'b0011001;
            4'h5: seg_next = 7'b0010010;
            4'h6: seg_next = 7'b0000010;
            4'h7: seg_next = 7'b1111000;
            4'h8: seg_next = 7'b0000000;
            4'h9: seg_next = 7'b0010000;
            4'hA: seg_next = 7'b0001000;
            4'hB: seg_next = 7'b0000011;
            4'hC: seg_next = 7'b1000110;
            4'hD: seg_next = 7'b0100001;
            4'hE: seg_next = 7'b0000110;
            4'hF: seg_next = 7'b0001110;
            default: seg_next = 7'h7F;
        endcase
    end

    // Slot counter and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Double buffer: strobes land in pending, commit to display only at frame wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_val  <= 16'h0000;
            pend_dp   <= 4'h0;
            pend_full <= 1'b0;
            disp_val  <= 16'h0000;
            disp_dp   <= 4'h0;
        end else if (wrap && capture) begin
            disp_val  <= value_in;
            disp_dp   <= dp_in;
            pend_full <= 1'b0;
        end else begin
            if (capture) begin
                pend_val  <= value_in;
                pend_dp   <= dp_in;
                pend_full <= 1'b1;
            end
            if (wrap && pend_full) begin
                disp_val  <= pend_val;
                disp_dp   <= pend_dp;
                pend_full <= 1'b0;
            end
        end
    end

    // Registered outputs; frame_tick is delayed so it coincides with slot 0's first output cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg        <= 7'h7F;
            dp         <= 1'b1;
            an         <= 4'hF;
            wrap_q     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_next;
            dp         <= ~disp_dp[idx];
            an         <= an_next;
            wrap_q     <= wrap;
            frame_tick <= wrap_q;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - self-checking bench for seg7_scan_display
module tb_seg7_scan_display;

    localparam int CF    = 400;
    localparam int RH    = 10;
    localparam int BC    = 2;
    localparam int DT    = CF / (4 * RH);
    localparam int FRAME = 4 * DT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value_in = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        value_valid = 1'b0;
    logic        freeze = 1'b0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    int tests = 0;
    int fails = 0;

    // reference model: edges since reset release, shown value, most recent accepted value
    int          n = 0;
    logic [15:0] m_disp = 16'h0000;
    logic [3:0]  m_dp = 4'h0;
    logic [15:0] m_last = 16'h0000;
    logic [3:0]  m_last_dp = 4'h0;
    logic [3:0]  exp_an = 4'hF;
    logic [12:0] exp_out = 13'h0;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg7_scan_display #(
        .CLOCK_FREQ  (CF),
        .REFRESH_HZ  (RH),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .value_valid(value_valid),
        .freeze     (freeze),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // observed outputs; seg/dp only matter while the expected anode is lit
    function automatic logic [12:0] obs();
        logic lit;
        lit = (exp_an != 4'hF);
        return {frame_tick, an, lit ? seg : 7'h00, lit ? dp : 1'b0};
    endfunction

    // one clock edge: predict outputs from the pre-edge position, then apply the strobe
    task automatic tick();
        int p, d, c;
        logic [15:0] sh;
        logic blanked, lit, ft;
        @(posedge clk);
        if (!rst) begin
            p = n % FRAME;
            n++;
            d = p / DT;
            c = p % DT;
            sh = m_disp >> (4 * d);
            blanked = blank_lz && (d != 0) && (sh == 16'h0000);
            exp_an = 4'hF;
            if (c >= BC && !blanked) exp_an[d] = 1'b0;
            lit = (exp_an != 4'hF);
            ft = (p == 0) && (n > 1);
            exp_out = {ft, exp_an, lit ? seg_tab[sh[3:0]] : 7'h00, lit ? ~m_dp[d] : 1'b0};
            if (value_valid && !freeze) begin
                m_last = value_in;
                m_last_dp = dp_in;
            end
            if (p == FRAME - 1) begin
                m_disp = m_last;
                m_dp = m_last_dp;
            end
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        n = 0;
        m_disp = 16'h0000;
        m_dp = 4'h0;
        m_last = 16'h0000;
        m_last_dp = 4'h0;
        exp_an = 4'hF;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({frame_tick, an, seg, dp} !== {1'b0, 4'hF, 7'h7F, 1'b1}) begin
            fails++;
            $display("FAIL reset_values got=%h want=%h", {frame_tick, an, seg, dp}, {1'b0, 4'hF, 7'h7F, 1'b1});
        end
        rst = 1'b0;
        repeat (2 * FRAME + 5) begin
            tick();
            tests++;
            if (obs() !== exp_out) begin
                fails++;
                $display("FAIL reset_scan n=%0d got=%h want=%h", n, obs(), exp_out);
            end
        end
    endtask

    task automatic test_full_decode();
        while (n % FRAME != 15) begin
            tick();
            tests++;
            if (obs() !== exp_out) begin fails++; $display("FAIL decode_pre n=%0d got=%h want=%h", n, obs(), exp_out); end
        end
        value_in = 16'h1A3F; dp_in = 4'b0100; value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        repeat (2 * FRAME) begin
            tick();
            tests++;
            if (obs() !== exp_out) begin fails++; $display("FAIL decode n=%0d got=%h want=%h", n, obs(), exp_out); end
        end
    endtask

    task automatic test_leading_zero();
        blank_lz = 1'b1;
        while (n % FRAME != 5) tick();
        value_in = 16'h0040; dp_in = 4'h0; value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        repeat (2 * FRAME) begin
            tick();
            tests++;
            if (obs() !== exp_out) begin fails++; $display("FAIL lz_on n=%0d got=%h want=%h", n, obs(), exp_out); end
        end
        blank_lz = 1'b0;
        repeat (FRAME) begin
            tick();
            tests++;
            if (obs() !== exp_out) begin fails++; $display("FAIL lz_off n=%0d got=%h want=%h", n, obs(), exp_out); end
        end
    endtask

    task automatic test_zero_value();
        blank_lz = 1'b1;
        value_in = 16'h0000; dp_in = 4'h0; value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        repeat (2 * FRAME) begin
            tick();
            tests++;
            if (obs() !== exp_out) begin fails++; $display("FAIL zero n=%0d got=%h want=%h", n, obs(), exp_out); end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_freeze_coincident();
        while (n % FRAME != 5) tick();
        value_in = 16'h1111; dp_in = 4'h1; value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        repeat (4) tick();
        value_in = 16'h2222; dp_in = 4'h2; freeze = 1'b1; value_valid = 1'b1;
        tick();
        value_valid = 1'b0; freeze = 1'b0;
        repeat (2 * FRAME) begin
            tick();
            tests++;
            if (obs() !== exp_out) begin fails++; $display("FAIL freeze n=%0d got=%h want=%h", n, obs(), exp_out); end
        end
        while (n % FRAME != 20) tick();
        value_in = 16'h4444; dp_in = 4'h4; value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        while (n % FRAME != FRAME - 1) begin
            tick();
            tests++;
            if (obs() !== exp_out) begin fails++; $display("FAIL wrap_pre n=%0d got=%h want=%h", n, obs(), exp_out); end
        end
        value_in = 16'h3333; dp_in = 4'h8; value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        tests++;
        if (dut.pend_full !== 1'b0) begin fails++; $display("FAIL wrap_pend_full got=%b want=0", dut.pend_full); end
        repeat (FRAME + 2) begin
            tick();
            tests++;
            if (obs() !== exp_out) begin fails++; $display("FAIL wrap_strobe n=%0d got=%h want=%h", n, obs(), exp_out); end
        end
    endtask

    task automatic test_reset_mid_frame();
        while (n % FRAME != 3) tick();
        value_in = 16'h5A5A; dp_in = 4'hF; value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        while (n % FRAME != 25) tick();
        rst = 1'b1;
        model_reset();
        #1;
        tests++;
        if ({frame_tick, an, seg, dp} !== {1'b0, 4'hF, 7'h7F, 1'b1}) begin
            fails++;
            $display("FAIL midreset_values got=%h want=%h", {frame_tick, an, seg, dp}, {1'b0, 4'hF, 7'h7F, 1'b1});
        end
        repeat (2) tick();
        rst = 1'b0;
        repeat (2 * FRAME + 2) begin
            tick();
            tests++;
            if (obs() !== exp_out) begin fails++; $display("FAIL midreset_scan n=%0d got=%h want=%h", n, obs(), exp_out); end
        end
    endtask

    task automatic test_random();
        repeat (8 * FRAME) begin
            value_valid = ($urandom_range(0, 5) == 0);
            value_in = 16'($urandom);
            dp_in = 4'($urandom);
            freeze = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 40) == 0) blank_lz = ~blank_lz;
            tick();
            tests++;
            if (obs() !== exp_out) begin fails++; $display("FAIL random n=%0d got=%h want=%h", n, obs(), exp_out); end
        end
        value_valid = 1'b0;
        freeze = 1'b0;
        repeat (2 * FRAME) begin
            tick();
            tests++;
            if (obs() !== exp_out) begin fails++; $display("FAIL random_tail n=%0d got=%h want=%h", n, obs(), exp_out); end
        end
    endtask

    initial begin
        test_reset();
        test_full_decode();
        test_leading_zero();
        test_zero_value();
        test_freeze_coincident();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
